head_op_scheduler: RTL

//  Sequences operations onto one head core array. Queues op descriptors from the top-level controller and,
//  for each one, broadcasts its config and control state. It then pulses start, waits for the array's
//  one-cycle finish and reports completion with tag and cycle count. A watchdog flags hung ops.

---
 rtl/head_sched_pkg.sv | 27 ++
 rtl/sched_desc_fifo.sv | 79 +++++++
 rtl/head_op_scheduler.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/head_sched_pkg.sv
// Shared types and widths for the head core array operation scheduler.
package head_sched_pkg;

    localparam int OP_CFG_W     = 41;
    localparam int USR_CFG_W    = 12;
    localparam int CTRL_STATE_W = 32;
    // Tags are carried at this width inside the queue and truncated to
    // TAG_WIDTH at the scheduler; TAG_WIDTH must not exceed it.
    localparam int TAG_W_MAX    = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CFG   = 3'd1,
        ST_START = 3'd2,
        ST_BUSY  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_t;

    typedef struct packed {
        logic [OP_CFG_W-1:0]     op_cfg;
        logic [CTRL_STATE_W-1:0] ctrl_state;
        logic [USR_CFG_W-1:0]    usr_cfg;
        logic                    usr_upd;
        logic [TAG_W_MAX-1:0]    tag;
    } sched_desc_t;

endpackage

// File: rtl/sched_desc_fifo.sv
// Synchronous descriptor queue with flush. The head entry is read
// combinationally so the scheduler can pop straight into its holding
// registers in the same cycle it decides to start the op.
module sched_desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             full_next,
    output logic             empty_next
);

    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              push_en;
    logic              pop_en;

    assign full       = (count_reg == CNT_W'(DEPTH));
    assign empty      = (count_reg == '0);
    assign full_next  = (count_next == CNT_W'(DEPTH));
    assign empty_next = (count_next == '0);
    assign rd_data    = mem[rd_ptr_reg];

    // Qualify requests: flush wins over both, push is dropped while full.
    always_comb begin
        push_en    = push && !full && !flush;
        pop_en     = pop && !empty && !flush;
        count_next = count_reg;
        if (flush) begin
            count_next = '0;
        end else begin
            case ({push_en, pop_en})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so the
    // pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
            end
            count_reg <= count_next;
        end
    end

    // Storage write; contents need no reset since occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: rtl/head_op_scheduler.sv
// Sequences queued op descriptors onto the head core array: broadcast
// config, pulse start, wait for finish (or the watchdog), report done.
module head_op_scheduler
    import head_sched_pkg::*;
#(
    parameter int FIFO_DEPTH    = 4,
    parameter int TAG_WIDTH     = 4,
    parameter int CYC_CNT_WIDTH = 24,
    parameter int WDOG_CYCLES   = 2**20
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [OP_CFG_W-1:0]      cmd_op_cfg,
    input  logic [CTRL_STATE_W-1:0]  cmd_ctrl_state,
    input  logic [USR_CFG_W-1:0]     cmd_usr_cfg,
    input  logic                     cmd_usr_upd,
    input  logic [TAG_WIDTH-1:0]     cmd_tag,
    input  logic                     abort,
    output logic                     op_cfg_vld,
    output logic [OP_CFG_W-1:0]      op_cfg,
    output logic                     usr_cfg_vld,
    output logic [USR_CFG_W-1:0]     usr_cfg,
    output logic                     control_state_update,
    output logic [CTRL_STATE_W-1:0]  control_state,
    output logic                     start,
    input  logic                     finish,
    output logic                     done_vld,
    output logic [TAG_WIDTH-1:0]     done_tag,
    output logic [CYC_CNT_WIDTH-1:0] done_cycles,
    output logic                     done_timeout,
    output logic                     err_spurious,
    output logic                     busy
);

    localparam int DESC_W = $bits(sched_desc_t);
    localparam logic [CYC_CNT_WIDTH-1:0] WDOG_LIMIT = CYC_CNT_WIDTH'(WDOG_CYCLES - 1);

    function automatic logic [CYC_CNT_WIDTH-1:0] sat_inc(input logic [CYC_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CYC_CNT_WIDTH'(1);
    endfunction

    sched_state_t               state_reg;
    sched_desc_t                cmd_desc;
    sched_desc_t                fifo_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fifo_full_next;
    logic                       fifo_empty_next;
    logic                       push;
    logic                       pop;

    logic                       cmd_rdy_reg;
    logic                       op_cfg_vld_reg;
    logic [OP_CFG_W-1:0]        op_cfg_reg;
    logic                       usr_cfg_vld_reg;
    logic [USR_CFG_W-1:0]       usr_cfg_reg;
    logic                       ctrl_upd_reg;
    logic [CTRL_STATE_W-1:0]    ctrl_state_reg;
    logic                       start_reg;
    logic [TAG_WIDTH-1:0]       tag_reg;
    logic [CYC_CNT_WIDTH-1:0]   cyc_cnt_reg;
    logic                       done_vld_reg;
    logic [TAG_WIDTH-1:0]       done_tag_reg;
    logic [CYC_CNT_WIDTH-1:0]   done_cycles_reg;
    logic                       done_timeout_reg;
    logic                       err_spurious_reg;
    logic                       busy_reg;

    // Assemble the incoming descriptor; the tag is zero-extended into the queue.
    always_comb begin
        cmd_desc            = '0;
        cmd_desc.op_cfg     = cmd_op_cfg;
        cmd_desc.ctrl_state = cmd_ctrl_state;
        cmd_desc.usr_cfg    = cmd_usr_cfg;
        cmd_desc.usr_upd    = cmd_usr_upd;
        cmd_desc.tag        = TAG_W_MAX'(cmd_tag);
    end

    // abort drops a same-cycle push and blocks a same-cycle pop so the
    // flushed head never starts.
    assign push = cmd_vld && cmd_rdy_reg && !abort;
    assign pop  = (state_reg == ST_IDLE) && !fifo_empty && !abort;

    sched_desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_desc_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (abort),
        .push       (push),
        .pop        (pop),
        .wr_data    (cmd_desc),
        .rd_data    (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .full_next  (fifo_full_next),
        .empty_next (fifo_empty_next)
    );

    // Upper tag bits are always zero in the queue when TAG_WIDTH is narrower.
    generate
        if (TAG_WIDTH < TAG_W_MAX) begin : g_tag_pad
            logic unused_tag_hi;
            assign unused_tag_hi = |fifo_head.tag[TAG_W_MAX-1:TAG_WIDTH];
        end
    endgenerate

    // Op sequencer: every output is set on the edge that enters its state so
    // the pulses line up exactly with CFG, START and DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            op_cfg_vld_reg   <= 1'b0;
            op_cfg_reg       <= '0;
            usr_cfg_vld_reg  <= 1'b0;
            usr_cfg_reg      <= '0;
            ctrl_upd_reg     <= 1'b0;
            ctrl_state_reg   <= '0;
            start_reg        <= 1'b0;
            tag_reg          <= '0;
            cyc_cnt_reg      <= '0;
            done_vld_reg     <= 1'b0;
            done_tag_reg     <= '0;
            done_cycles_reg  <= '0;
            done_timeout_reg <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            op_cfg_vld_reg   <= 1'b0;
            usr_cfg_vld_reg  <= 1'b0;
            ctrl_upd_reg     <= 1'b0;
            start_reg        <= 1'b0;
            done_vld_reg     <= 1'b0;
            done_timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        state_reg       <= ST_CFG;
                        op_cfg_vld_reg  <= 1'b1;
                        ctrl_upd_reg    <= 1'b1;
                        usr_cfg_vld_reg <= fifo_head.usr_upd;
                        op_cfg_reg      <= fifo_head.op_cfg;
                        ctrl_state_reg  <= fifo_head.ctrl_state;
                        usr_cfg_reg     <= fifo_head.usr_cfg;
                        tag_reg         <= fifo_head.tag[TAG_WIDTH-1:0];
                        busy_reg        <= 1'b1;
                    end else begin
                        busy_reg <= !fifo_empty_next;
                    end
                end
                ST_CFG: begin
                    state_reg   <= ST_START;
                    start_reg   <= 1'b1;
                    cyc_cnt_reg <= '0;
                    busy_reg    <= 1'b1;
                end
                ST_START: begin
                    state_reg <= ST_BUSY;
                    busy_reg  <= 1'b1;
                end
                ST_BUSY: begin
                    busy_reg <= 1'b1;
                    if (finish) begin
                        // Finish wins a tie with the watchdog limit.
                        state_reg       <= ST_DONE;
                        done_vld_reg    <= 1'b1;
                        done_tag_reg    <= tag_reg;
                        done_cycles_reg <= sat_inc(cyc_cnt_reg);
                    end else if (cyc_cnt_reg == WDOG_LIMIT) begin
                        state_reg        <= ST_DONE;
                        done_vld_reg     <= 1'b1;
                        done_timeout_reg <= 1'b1;
                        done_tag_reg     <= tag_reg;
                        done_cycles_reg  <= cyc_cnt_reg;
                    end else begin
                        cyc_cnt_reg <= sat_inc(cyc_cnt_reg);
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= !fifo_empty_next;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= !fifo_empty_next;
                end
            endcase
        end
    end

    // Queue ready tracks next-cycle fullness; finish outside BUSY is sticky.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_rdy_reg      <= 1'b0;
            err_spurious_reg <= 1'b0;
        end else begin
            cmd_rdy_reg <= !fifo_full_next;
            if (finish && (state_reg != ST_BUSY)) begin
                err_spurious_reg <= 1'b1;
            end
        end
    end

    assign cmd_rdy              = cmd_rdy_reg;
    assign op_cfg_vld           = op_cfg_vld_reg;
    assign op_cfg               = op_cfg_reg;
    assign usr_cfg_vld          = usr_cfg_vld_reg;
    assign usr_cfg              = usr_cfg_reg;
    assign control_state_update = ctrl_upd_reg;
    assign control_state        = ctrl_state_reg;
    assign start                = start_reg;
    assign done_vld             = done_vld_reg;
    assign done_tag             = done_tag_reg;
    assign done_cycles          = done_cycles_reg;
    assign done_timeout         = done_timeout_reg;
    assign err_spurious         = err_spurious_reg;
    assign busy                 = busy_reg;

endmodule
